instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Encoder counterpart of the control decoder. Accepts symbolic instruction
//  requests over a valid/ready handshake, packs each into an RV32I word, and
//  writes the words sequentially into instruction memory. Used as the
//  program loader in front of imem.
// PARAMETERS
//  ADDR_W  8  imem address width; depth DEPTH = 2**ADDR_W words
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous, active-high reset
//  start      in   1        begin a load session (honoured in IDLE/DONE)
//  finish     in   1        end session early (honoured in LOAD)
//  in_valid   in   1        request valid
//  in_ready   out  1        encoder can accept a request
//  in_op      in   3        0=NOP, 1=ADDI (same code as decoder alu_op), else illegal
//  in_rd      in   5        destination register
//  in_rs1     in   5        source register
//  in_imm12   in   12       immediate
//  mem_we     out  1        imem write strobe, one cycle per word
//  mem_addr   out  ADDR_W   imem write address
//  mem_wdata  out  32       encoded instruction word
//  busy       out  1        high in LOAD/PAD
//  done       out  1        high in DONE
//  count      out  ADDR_W+1 words written this session
//  err        out  1        sticky illegal-op flag, cleared by start
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready,mem_we,busy,done,err=0; mem_addr,mem_wdata,count=0.
//    rst mid-session drops any pending write; no mem_we the cycle after rst.
//  - Encoding: ADDI = {imm12, rs1, 3'b000, rd, 7'b0010011}; NOP = 32'h0000_0013
//    (rd/rs1/imm ignored).
//  - FSM IDLE -> (start) LOAD: clears wr_ptr, count, err, done.
//  - LOAD: in_ready=1 while count<DEPTH. Transfer = in_valid&in_ready.
//    Legal transfer: next cycle mem_we=1, mem_addr=wr_ptr, mem_wdata=word;
//    wr_ptr++, count++ (latency exactly 1, back-to-back allowed, 1 word/cycle).
//    Illegal op: handshake completes, no write, count unchanged, err<=1.
//  - Full: when count reaches DEPTH, in_ready drops the same cycle the last
//    write issues; FSM -> DONE. wr_ptr wraps to 0, never overwrites.
//  - finish in LOAD: a transfer in the same cycle is still accepted and
//    written; then -> PAD (macro on) or DONE (macro off). in_ready=0 after.
//  - DONE: done=1, busy=0, in_ready=0; start restarts LOAD (new session).
//    start in LOAD/PAD ignored; finish outside LOAD ignored.
//  - mem_addr/mem_wdata hold last written values when mem_we=0.
// CONFIGURATION
//  INSTR_ENCODER_NOP_PAD_EN defined: PAD state writes NOP (32'h0000_0013)
//    to every remaining address count..DEPTH-1, one per cycle, count
//    increments, then DONE with count=DEPTH. finish with count=DEPTH -> DONE.
//  Undefined: no PAD state; finish -> DONE directly, unwritten words untouched.
// TESTING
//  1. rst, start, ADDI rd=1 rs1=2 imm=5 -> next cycle mem_we=1 addr=0
//     wdata=32'h0051_0093; count=1.
//  2. ADDI rd=5 rs1=0 imm=12'hFFF then NOP back-to-back -> addr 0:
//     32'hFFF0_0293, addr 1: 32'h0000_0013, consecutive cycles.
//  3. op=3'd5 between two ADDIs -> no write for it, err=1, addresses
//     contiguous (0,1), count=2; next start clears err.
//  4. ADDR_W=2: stream 5 valid ADDIs -> 4 writes (addr 0..3), in_ready=0
//     after 4th, done=1, count=4, 5th never accepted.
//  5. ADDR_W=2, 1 ADDI then finish same cycle as 2nd ADDI -> both written;
//     macro on: NOPs at addr 2,3 then done, count=4; macro off: done, count=2.
//  6. rst asserted the cycle a transfer is accepted -> no mem_we following,
//     all outputs at reset values, in_ready=0 until next start.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: program loader placed in front of imem.
// Accepts symbolic NOP/ADDI requests over a valid/ready handshake, packs
// each one into an RV32I word and writes the words to consecutive imem
// addresses starting at 0, at most one word per cycle.
// Optional feature: define INSTR_ENCODER_NOP_PAD_EN to add a PAD state.
// After an early finish, that state fills the remaining addresses with NOPs.
// Without the macro, an early finish goes straight to DONE and leaves the
// unwritten words untouched.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [11:0]       in_imm12,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  // A session is full when count == DEPTH == 2**ADDR_W, i.e. only the MSB set.
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [31:0]     NOP_WORD = 32'h0000_0013;
  localparam logic [2:0]      OP_NOP   = 3'd0;
  localparam logic [2:0]      OP_ADDI  = 3'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PAD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // ADDI rd, rs1, imm12 in I-type layout (funct3 = 000, opcode = OP-IMM).
  function automatic logic [31:0] enc_addi(input logic [11:0] imm,
                                           input logic [4:0]  rs1,
                                           input logic [4:0]  rd);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  // Only NOP and ADDI are encodable; every other op code is reported via err.
  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_NOP) || (op == OP_ADDI);
  endfunction

  // Canonical NOP ignores rd/rs1/imm, so those fields cannot leak into it.
  function automatic logic [31:0] encode(input logic [2:0]  op,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  rs1,
                                         input logic [11:0] imm);
    return (op == OP_ADDI) ? enc_addi(imm, rs1, rd) : NOP_WORD;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;

  logic                xfer;
  logic [31:0]         req_word;

  // in_ready_q is only ever high in LOAD below DEPTH, so it fully qualifies
  // the handshake.
  assign xfer     = in_valid & in_ready_q;
  assign req_word = encode(in_op, in_rd, in_rs1, in_imm12);

  // Next-state and next-output computation for the loader FSM.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
          count_d  = '0;
          err_d    = 1'b0;
        end
      end

      S_LOAD: begin
        if (xfer) begin
          if (op_legal(in_op)) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_ptr_q;
            mem_wdata_d = req_word;
            wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
            count_d     = count_q + (ADDR_W+1)'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        // Reaching DEPTH wins over finish: nothing is left to pad.
        if (count_d == FULL_CNT) begin
          state_d = S_DONE;
        end else if (finish) begin
`ifdef INSTR_ENCODER_NOP_PAD_EN
          state_d = S_PAD;
`else
          state_d = S_DONE;
`endif
        end
      end

`ifdef INSTR_ENCODER_NOP_PAD_EN
      S_PAD: begin
        if (count_q == FULL_CNT) begin
          state_d = S_DONE;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_ptr_q;
          mem_wdata_d = NOP_WORD;
          wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
          count_d     = count_q + (ADDR_W+1)'(1);
          if (count_d == FULL_CNT) begin
            state_d = S_DONE;
          end
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are derived from the state being entered.
    // They therefore change on the same edge as the write that causes
    // the change.
    in_ready_d = (state_d == S_LOAD) && (count_d != FULL_CNT);
    busy_d     = (state_d == S_LOAD) || (state_d == S_PAD);
    done_d     = (state_d == S_DONE);
  end

  // State and registered outputs; reset drops any write that is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder with a 4-word imem (ADDR_W = 2).
// Directed vector table first, then randomized traffic against a session model.
module tb_instr_encoder;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              finish = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_op = '0;
  logic [4:0]        in_rd = '0;
  logic [4:0]        in_rs1 = '0;
  logic [11:0]       in_imm12 = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;
  logic              err;

  int errors = 0;
  int checks = 0;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_imm12(in_imm12),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  // Output snapshot: {we, addr, wdata, ready, busy, done, count, err}.
  function automatic logic [63:0] pack(bit we, int addr, logic [31:0] wd, bit rdy,
                                       bit bsy, bit dn, int cnt, bit er);
    return {22'd0, we, 2'(addr), wd, rdy, bsy, dn, 3'(cnt), er};
  endfunction

  function automatic logic [63:0] dut_snap();
    return pack(mem_we, int'(mem_addr), mem_wdata, in_ready, busy, done, int'(count), err);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got we=%0d addr=%0d wdata=%08h rdy=%0d busy=%0d done=%0d cnt=%0d err=%0d, expected we=%0d addr=%0d wdata=%08h rdy=%0d busy=%0d done=%0d cnt=%0d err=%0d",
               name, act[41], act[40:39], act[38:7], act[6], act[5], act[4], act[3:1], act[0],
               exp[41], exp[40:39], exp[38:7], exp[6], exp[5], exp[4], exp[3:1], exp[0]);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic apply(bit r, bit s, bit f, bit v, int op, int rd, int rs1, int imm);
    rst = r; start = s; finish = f; in_valid = v;
    in_op = 3'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_imm12 = 12'(imm);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst, start, fin, vld;
    int op, rd, rs1, imm;
    bit we; int addr; logic [31:0] wd;
    bit rdy, bsy, dn; int cnt; bit er;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit s, bit f, bit v, int op, int rd, int rs1, int imm,
                              bit we, int addr, logic [31:0] wd, bit rdy, bit bsy, bit dn,
                              int cnt, bit er);
    vec_t x;
    x.rst = r; x.start = s; x.fin = f; x.vld = v;
    x.op = op; x.rd = rd; x.rs1 = rs1; x.imm = imm;
    x.we = we; x.addr = addr; x.wd = wd; x.rdy = rdy; x.bsy = bsy; x.dn = dn;
    x.cnt = cnt; x.er = er;
    tbl.push_back(x);
  endfunction

  // ---------------- reference model ----------------
  // Session view: a request list is appended to imem at address == words so far.
  bit          m_open, m_padding, m_done, m_err, m_we;
  int          m_count, m_addr;
  logic [31:0] m_wdata;

  function automatic logic [31:0] ref_word(int op, int rd, int rs1, int imm);
    longint w;
    if (op != 1) return 32'h0000_0013;
    w = longint'(imm) * 1048576 + longint'(rs1) * 32768 + longint'(rd) * 128 + 19;
    return w[31:0];
  endfunction

  function automatic void model_step(bit r, bit s, bit f, bit v, int op, int rd, int rs1, int imm);
    m_we = 0;
    if (r) begin
      m_open = 0; m_padding = 0; m_done = 0; m_err = 0;
      m_count = 0; m_addr = 0; m_wdata = 0;
    end else if (m_padding) begin
      m_we = 1; m_addr = m_count % DEPTH; m_wdata = 32'h0000_0013;
      m_count++;
      if (m_count == DEPTH) begin m_padding = 0; m_done = 1; end
    end else if (m_open) begin
      if (v && m_count < DEPTH) begin
        if (op == 0 || op == 1) begin
          m_we = 1; m_addr = m_count; m_wdata = ref_word(op, rd, rs1, imm);
          m_count++;
        end else begin
          m_err = 1;
        end
      end
      if (m_count == DEPTH) begin
        m_open = 0; m_done = 1;
      end else if (f) begin
        m_open = 0;
`ifdef INSTR_ENCODER_NOP_PAD_EN
        m_padding = 1;
`else
        m_done = 1;
`endif
      end
    end else if (s) begin
      m_open = 1; m_done = 0; m_err = 0; m_count = 0;
    end
  endfunction

  function automatic logic [63:0] model_snap();
    return pack(m_we, m_addr, m_wdata, m_open && (m_count < DEPTH),
                m_open || m_padding, m_done, m_count, m_err);
  endfunction

  initial begin
    //  rst s f v  op rd rs1 imm     we addr wdata          rdy bsy dn cnt err
    add(1, 0,0,0, 0, 0, 0,  0,      0, 0, 32'h0000_0000, 0, 0, 0, 0, 0);
    add(0, 1,0,0, 0, 0, 0,  0,      0, 0, 32'h0000_0000, 1, 1, 0, 0, 0);
    add(0, 0,0,1, 1, 1, 2,  5,      1, 0, 32'h0051_0093, 1, 1, 0, 1, 0);
    add(0, 0,0,0, 1, 9, 9,  9,      0, 0, 32'h0051_0093, 1, 1, 0, 1, 0);
    add(1, 0,0,0, 0, 0, 0,  0,      0, 0, 32'h0000_0000, 0, 0, 0, 0, 0);
    add(0, 1,0,0, 0, 0, 0,  0,      0, 0, 32'h0000_0000, 1, 1, 0, 0, 0);
    add(0, 0,0,1, 1, 5, 0,  'hFFF,  1, 0, 32'hFFF0_0293, 1, 1, 0, 1, 0);
    add(0, 0,0,1, 0, 7, 3,  'h123,  1, 1, 32'h0000_0013, 1, 1, 0, 2, 0);
    add(0, 0,0,1, 5, 2, 2,  2,      0, 1, 32'h0000_0013, 1, 1, 0, 2, 1);
    add(0, 1,0,1, 1, 3, 4,  1,      1, 2, 32'h0012_0193, 1, 1, 0, 3, 1);
    add(0, 0,0,1, 1, 31,31, 'h800,  1, 3, 32'h800F_8F93, 0, 0, 1, 4, 1);
    add(0, 0,0,1, 1, 1, 1,  1,      0, 3, 32'h800F_8F93, 0, 0, 1, 4, 1);
    add(0, 0,1,0, 0, 0, 0,  0,      0, 3, 32'h800F_8F93, 0, 0, 1, 4, 1);
    add(0, 1,0,0, 0, 0, 0,  0,      0, 3, 32'h800F_8F93, 1, 1, 0, 0, 0);
    add(1, 0,0,1, 1, 1, 2,  5,      0, 0, 32'h0000_0000, 0, 0, 0, 0, 0);
    add(0, 0,0,1, 1, 1, 2,  5,      0, 0, 32'h0000_0000, 0, 0, 0, 0, 0);
    add(0, 0,0,0, 0, 0, 0,  0,      0, 0, 32'h0000_0000, 0, 0, 0, 0, 0);
    // early finish on the 2nd request of a session
    add(0, 1,0,0, 0, 0, 0,  0,      0, 0, 32'h0000_0000, 1, 1, 0, 0, 0);
    add(0, 0,0,1, 1, 1, 2,  5,      1, 0, 32'h0051_0093, 1, 1, 0, 1, 0);
`ifdef INSTR_ENCODER_NOP_PAD_EN
    add(0, 0,1,1, 1, 5, 0,  'hFFF,  1, 1, 32'hFFF0_0293, 0, 1, 0, 2, 0);
    add(0, 1,0,1, 1, 1, 1,  1,      1, 2, 32'h0000_0013, 0, 1, 0, 3, 0);
    add(0, 0,0,0, 0, 0, 0,  0,      1, 3, 32'h0000_0013, 0, 0, 1, 4, 0);
    add(0, 0,0,0, 0, 0, 0,  0,      0, 3, 32'h0000_0013, 0, 0, 1, 4, 0);
`else
    add(0, 0,1,1, 1, 5, 0,  'hFFF,  1, 1, 32'hFFF0_0293, 0, 0, 1, 2, 0);
    add(0, 0,0,1, 1, 1, 1,  1,      0, 1, 32'hFFF0_0293, 0, 0, 1, 2, 0);
    add(0, 0,0,0, 0, 0, 0,  0,      0, 1, 32'hFFF0_0293, 0, 0, 1, 2, 0);
`endif

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].start, tbl[i].fin, tbl[i].vld,
            tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].imm);
      chk($sformatf("vec%0d", i), dut_snap(),
          pack(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].rdy, tbl[i].bsy,
               tbl[i].dn, tbl[i].cnt, tbl[i].er));
    end

    // Randomized traffic; the first cycle resets both DUT and model.
    for (int c = 0; c < 4000; c++) begin
      bit r, s, f, v;
      int op, rd, rs1, imm;
      r   = (c == 0) || ($urandom_range(0, 99) < 2);
      s   = $urandom_range(0, 99) < 15;
      f   = $urandom_range(0, 99) < 8;
      v   = $urandom_range(0, 99) < 60;
      op  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 7));
      rd  = int'($urandom_range(0, 31));
      rs1 = int'($urandom_range(0, 31));
      imm = int'($urandom_range(0, 4095));
      apply(r, s, f, v, op, rd, rs1, imm);
      model_step(r, s, f, v, op, rd, rs1, imm);
      chk($sformatf("rand%0d", c), dut_snap(), model_snap());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
